// File: rtl/layer_compositor.sv
// layer_compositor: LAYERS-stage alpha-blending pipeline with a single
// global-advance valid/ready handshake.
//
// Stage k blends foreground layer k over the result of stage k-1; stage 0
// blends layer 0 over the background. Each stage carries the fg/alpha/enable
// payload of the layers above it, so every stage only needs the pixel it was
// handed.
//
// Optional build macro: LAYER_COMPOSITOR_ROUND_EN
//   defined   -> blend rounds half up (adds 2^(AW-1) before the shift)
//   undefined -> blend truncates
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   s_valid_i      input pixel valid
//   s_ready_o      input pixel accepted when high with s_valid_i
//   s_de_i         display-enable sideband
//   s_bg_i         background pixel {R,G,B}
//   s_fg_i         foreground pixels, layer k in slice k (layer 0 at bottom)
//   s_alpha_i      per-layer alpha, slice k for layer k
//   s_layer_en_i   per-layer enable
//   m_valid_o      output pixel valid
//   m_ready_i      downstream ready
//   m_de_o         display-enable delayed with the pixel
//   m_rgb_o        composited pixel {R,G,B}, zero whenever m_de_o is low
module layer_compositor #(
   parameter int unsigned CW     = 4,
   parameter int unsigned AW     = 3,
   parameter int unsigned LAYERS = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     s_valid_i,
   output logic                     s_ready_o,
   input  logic                     s_de_i,
   input  logic [3*CW-1:0]          s_bg_i,
   input  logic [LAYERS*3*CW-1:0]   s_fg_i,
   input  logic [LAYERS*AW-1:0]     s_alpha_i,
   input  logic [LAYERS-1:0]        s_layer_en_i,
   output logic                     m_valid_o,
   input  logic                     m_ready_i,
   output logic                     m_de_o,
   output logic [3*CW-1:0]          m_rgb_o
);

   localparam int unsigned PW   = 3 * CW;         // pixel width
   localparam int unsigned LW   = PW + AW + 1;    // per-layer payload {en, alpha, fg}
   localparam int unsigned BW   = CW + AW + 1;    // blend intermediate width
   localparam int unsigned WMAX = 1 << AW;        // full-scale weight
`ifdef LAYER_COMPOSITOR_ROUND_EN
   localparam int unsigned RND  = 1 << (AW - 1);
`else
   localparam int unsigned RND  = 0;
`endif

   // Per-channel blend: (fg*w + bg*(2^AW-w) + r) >> AW; cannot exceed 2^CW-1.
   function automatic logic [PW-1:0] blend_px(input logic [PW-1:0] fg,
                                              input logic [PW-1:0] bg,
                                              input logic [AW:0]   w);
      logic [PW-1:0] res;
      logic [BW-1:0] acc;
      res = '0;
      for (int c = 0; c < 3; c++) begin
         acc = BW'(fg[c*CW +: CW]) * BW'(w)
             + BW'(bg[c*CW +: CW]) * (BW'(WMAX) - BW'(w))
             + BW'(RND);
         res[c*CW +: CW] = CW'(acc >> AW);
      end
      return res;
   endfunction

   logic                   w_adv;
   logic [LAYERS*LW-1:0]   w_lay_in;

   // Whole pipeline moves together unless the output is held by the sink.
   assign w_adv     = !m_valid_o || m_ready_i;
   assign s_ready_o = w_adv;

   // Repack the input layers as {en, alpha, fg} records, layer 0 lowest.
   for (genvar l = 0; l < LAYERS; l++) begin : g_pack
      assign w_lay_in[l*LW +: LW] = {s_layer_en_i[l], s_alpha_i[l*AW +: AW], s_fg_i[l*PW +: PW]};
   end

   for (genvar k = 0; k < LAYERS; k++) begin : g_stage
      localparam int unsigned NIN = LAYERS - k;   // layers k..LAYERS-1 arrive here

      logic [NIN*LW-1:0] w_lay;
      logic [PW-1:0]     w_acc;
      logic              w_vin;
      logic              w_dein;
      logic [PW-1:0]     w_fg;
      logic [AW-1:0]     w_a;
      logic              w_en;
      logic [AW:0]       w_w;
      logic [PW-1:0]     w_res;
      logic [PW-1:0]     w_out;

      logic              r_valid;
      logic              r_de;
      logic [PW-1:0]     r_rgb;

      if (k == 0) begin : g_src
         assign w_lay  = w_lay_in;
         assign w_acc  = s_bg_i;
         assign w_vin  = s_valid_i;
         assign w_dein = s_de_i;
      end else begin : g_src
         assign w_lay  = g_stage[k-1].g_up.r_up;
         assign w_acc  = g_stage[k-1].r_rgb;
         assign w_vin  = g_stage[k-1].r_valid;
         assign w_dein = g_stage[k-1].r_de;
      end

      assign w_fg = w_lay[PW-1:0];
      assign w_a  = w_lay[PW +: AW];
      assign w_en = w_lay[PW + AW];

      // Top alpha code maps to full weight so that layer is passed exactly.
      assign w_w   = (w_a == {AW{1'b1}}) ? (AW+1)'(WMAX) : {1'b0, w_a};
      assign w_res = w_en ? blend_px(w_fg, w_acc, w_w) : w_acc;
      // Blanked pixels and bubbles carry black.
      assign w_out = (w_vin && w_dein) ? w_res : '0;

      // Stage result register.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_valid <= 1'b0;
            r_de    <= 1'b0;
            r_rgb   <= '0;
         end else if (w_adv) begin
            r_valid <= w_vin;
            r_de    <= w_vin & w_dein;
            r_rgb   <= w_out;
         end
      end

      // Payload of the layers still to be blended by later stages.
      if (k < LAYERS - 1) begin : g_up
         logic [(NIN-1)*LW-1:0] r_up;
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_up <= '0;
            end else if (w_adv) begin
               r_up <= w_lay[NIN*LW-1:LW];
            end
         end
      end
   end

   assign m_valid_o = g_stage[LAYERS-1].r_valid;
   assign m_de_o    = g_stage[LAYERS-1].r_de;
   assign m_rgb_o   = g_stage[LAYERS-1].r_rgb;

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor (CW=4, AW=3, LAYERS=2).
// Reference model blends layers with plain integer arithmetic and keeps
// expected pixels in a queue.
module tb_layer_compositor;

   localparam int CW = 4;
   localparam int AW = 3;
   localparam int L  = 2;
`ifdef LAYER_COMPOSITOR_ROUND_EN
   localparam int RND = 4;
   localparam logic [11:0] ROUND_EXP = 12'h666;
`else
   localparam int RND = 0;
   localparam logic [11:0] ROUND_EXP = 12'h555;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          s_valid_i;
   logic          s_ready_o;
   logic          s_de_i;
   logic [11:0]   s_bg_i;
   logic [23:0]   s_fg_i;
   logic [5:0]    s_alpha_i;
   logic [1:0]    s_layer_en_i;
   logic          m_valid_o;
   logic          m_ready_i;
   logic          m_de_o;
   logic [11:0]   m_rgb_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   layer_compositor #(.CW(CW), .AW(AW), .LAYERS(L)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .s_valid_i    (s_valid_i),
      .s_ready_o    (s_ready_o),
      .s_de_i       (s_de_i),
      .s_bg_i       (s_bg_i),
      .s_fg_i       (s_fg_i),
      .s_alpha_i    (s_alpha_i),
      .s_layer_en_i (s_layer_en_i),
      .m_valid_o    (m_valid_o),
      .m_ready_i    (m_ready_i),
      .m_de_o       (m_de_o),
      .m_rgb_o      (m_rgb_o)
   );

   // Reference: start from bg, lay each enabled layer on top in order.
   function automatic logic [11:0] ref_px(input logic [11:0] bg, input logic [23:0] fg,
                                          input logic [5:0] al, input logic [1:0] en,
                                          input logic de);
      int acc, w, a, f;
      logic [11:0] res;
      res = 12'h000;
      if (!de) return res;
      for (int c = 0; c < 3; c++) begin
         acc = int'(bg[c*4 +: 4]);
         for (int l = 0; l < L; l++) begin
            if (en[l]) begin
               a   = int'(al[l*3 +: 3]);
               w   = (a == 7) ? 8 : a;
               f   = int'(fg[l*12 + c*4 +: 4]);
               acc = (f * w + acc * (8 - w) + RND) / 8;
            end
         end
         res[c*4 +: 4] = 4'(acc);
      end
      return res;
   endfunction

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_px(input logic [11:0] bg, input logic [23:0] fg,
                           input logic [5:0] al, input logic [1:0] en, input logic de);
      s_bg_i = bg; s_fg_i = fg; s_alpha_i = al; s_layer_en_i = en; s_de_i = de;
   endtask

   task automatic drive_rand;
      drive_px(12'($urandom), 24'($urandom), 6'($urandom), 2'($urandom), 1'($urandom_range(0, 7) != 0));
   endtask

   task automatic test_reset;
      rst_i = 1'b1; m_ready_i = 1'b0; s_valid_i = 1'b1;
      drive_px(12'hABC, 24'h123456, 6'h3F, 2'b11, 1'b1);
      tick; tick;
      #1;
      n_cmp++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", m_valid_o); end
      n_cmp++; if (m_de_o !== 1'b0) begin n_err++; $display("FAIL reset_de got %b want 0", m_de_o); end
      n_cmp++; if (m_rgb_o !== 12'h000) begin n_err++; $display("FAIL reset_rgb got %h want 000", m_rgb_o); end
      n_cmp++; if (s_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", s_ready_o); end
      rst_i = 1'b0; s_valid_i = 1'b0;
      tick;
   endtask

   task automatic test_passthrough;
      m_ready_i = 1'b1;
      drive_px(12'h5A3, 24'($urandom), 6'h00, 2'b11, 1'b1);
      s_valid_i = 1'b1;
      #1;
      n_cmp++; if (s_ready_o !== 1'b1) begin n_err++; $display("FAIL pass_ready got %b want 1", s_ready_o); end
      tick;
      s_valid_i = 1'b0;
      n_cmp++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL pass_early got valid %b want 0", m_valid_o); end
      tick;
      n_cmp++; if (m_valid_o !== 1'b1) begin n_err++; $display("FAIL pass_latency got valid %b want 1", m_valid_o); end
      n_cmp++; if (m_rgb_o !== 12'h5A3) begin n_err++; $display("FAIL pass_rgb got %h want 5a3", m_rgb_o); end
      n_cmp++; if (m_de_o !== 1'b1) begin n_err++; $display("FAIL pass_de got %b want 1", m_de_o); end
      tick;
      n_cmp++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL pass_dup got valid %b want 0", m_valid_o); end
   endtask

   task automatic test_opaque;
      m_ready_i = 1'b1;
      drive_px(12'($urandom), {12'hF00, 12'($urandom)}, {3'd7, 3'($urandom)}, {1'b1, 1'($urandom)}, 1'b1);
      s_valid_i = 1'b1;
      tick;
      s_valid_i = 1'b0;
      tick;
      n_cmp++; if (m_valid_o !== 1'b1 || m_rgb_o !== 12'hF00)
         begin n_err++; $display("FAIL opaque got v=%b rgb=%h want v=1 rgb=f00", m_valid_o, m_rgb_o); end
      tick;
   endtask

   task automatic test_rounding;
      m_ready_i = 1'b1;
      drive_px(12'h000, {12'($urandom), 12'hFFF}, {3'($urandom), 3'd3}, 2'b01, 1'b1);
      s_valid_i = 1'b1;
      tick;
      s_valid_i = 1'b0;
      tick;
      n_cmp++; if (m_valid_o !== 1'b1 || m_rgb_o !== ROUND_EXP)
         begin n_err++; $display("FAIL rounding got v=%b rgb=%h want v=1 rgb=%h", m_valid_o, m_rgb_o, ROUND_EXP); end
      tick;
   endtask

   task automatic test_blanking;
      m_ready_i = 1'b1;
      drive_px(12'($urandom) | 12'h111, 24'($urandom) | 24'h111111, 6'($urandom), 2'b11, 1'b0);
      s_valid_i = 1'b1;
      tick;
      s_valid_i = 1'b0;
      tick;
      n_cmp++; if (m_valid_o !== 1'b1) begin n_err++; $display("FAIL blank_valid got %b want 1", m_valid_o); end
      n_cmp++; if (m_de_o !== 1'b0) begin n_err++; $display("FAIL blank_de got %b want 0", m_de_o); end
      n_cmp++; if (m_rgb_o !== 12'h000) begin n_err++; $display("FAIL blank_rgb got %h want 000", m_rgb_o); end
      tick;
   endtask

   // Ten distinct pixels, sink stalls for three cycles mid-stream.
   task automatic test_backpressure;
      logic [12:0] q[$];
      logic [12:0] exp_px;
      logic        held;
      logic [12:0] held_px;
      int          sent, got;
      sent = 0; got = 0; held = 1'b0; held_px = '0;
      for (int t = 0; t < 40 && got < 10; t++) begin
         s_valid_i = (sent < 10);
         drive_px(12'(sent * 12'h123 + 12'h011), 24'($urandom), 6'($urandom), 2'($urandom), 1'b1);
         m_ready_i = !(t >= 4 && t <= 6);
         #1;
         n_cmp++; if (s_ready_o !== (!m_valid_o || m_ready_i))
            begin n_err++; $display("FAIL bp_ready t=%0d got %b want %b", t, s_ready_o, !m_valid_o || m_ready_i); end
         if (t >= 4 && t <= 6) begin
            n_cmp++; if (s_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready t=%0d got %b want 0", t, s_ready_o); end
         end
         if (held) begin
            n_cmp++; if (m_valid_o !== 1'b1 || {m_de_o, m_rgb_o} !== held_px)
               begin n_err++; $display("FAIL bp_hold t=%0d got v=%b px=%h want v=1 px=%h", t, m_valid_o, {m_de_o, m_rgb_o}, held_px); end
         end
         if (m_valid_o && m_ready_i) begin
            got++;
            exp_px = (q.size() != 0) ? q.pop_front() : 13'h1FFF;
            n_cmp++; if ({m_de_o, m_rgb_o} !== exp_px)
               begin n_err++; $display("FAIL bp_order pix=%0d got %h want %h", got, {m_de_o, m_rgb_o}, exp_px); end
         end
         if (s_valid_i && s_ready_o) begin
            q.push_back({s_de_i, ref_px(s_bg_i, s_fg_i, s_alpha_i, s_layer_en_i, s_de_i)});
            sent++;
         end
         held = m_valid_o && !m_ready_i;
         held_px = {m_de_o, m_rgb_o};
         tick;
      end
      s_valid_i = 1'b0; m_ready_i = 1'b1;
      n_cmp++; if (got !== 10) begin n_err++; $display("FAIL bp_count got %0d want 10", got); end
      tick; tick;
   endtask

   // Random traffic on both sides, scoreboarded against the model.
   task automatic test_random_stream;
      logic [12:0] q[$];
      logic [12:0] exp_px;
      logic        held;
      logic [12:0] held_px;
      int          sent, got;
      sent = 0; got = 0; held = 1'b0; held_px = '0;
      for (int t = 0; t < 260; t++) begin
         s_valid_i = (t < 220) && ($urandom_range(0, 9) < 7);
         drive_rand();
         m_ready_i = (t >= 220) || ($urandom_range(0, 9) < 6);
         #1;
         n_cmp++; if (s_ready_o !== (!m_valid_o || m_ready_i))
            begin n_err++; $display("FAIL rnd_ready t=%0d got %b want %b", t, s_ready_o, !m_valid_o || m_ready_i); end
         if (held) begin
            n_cmp++; if (m_valid_o !== 1'b1 || {m_de_o, m_rgb_o} !== held_px)
               begin n_err++; $display("FAIL rnd_hold t=%0d got v=%b px=%h want v=1 px=%h", t, m_valid_o, {m_de_o, m_rgb_o}, held_px); end
         end
         if (m_valid_o && m_ready_i) begin
            got++;
            exp_px = (q.size() != 0) ? q.pop_front() : 13'h1FFF;
            n_cmp++; if ({m_de_o, m_rgb_o} !== exp_px)
               begin n_err++; $display("FAIL rnd_data pix=%0d got %h want %h", got, {m_de_o, m_rgb_o}, exp_px); end
         end
         if (s_valid_i && s_ready_o) begin
            q.push_back({s_de_i, ref_px(s_bg_i, s_fg_i, s_alpha_i, s_layer_en_i, s_de_i)});
            sent++;
         end
         held = m_valid_o && !m_ready_i;
         held_px = {m_de_o, m_rgb_o};
         tick;
      end
      s_valid_i = 1'b0;
      n_cmp++; if (got !== sent) begin n_err++; $display("FAIL rnd_count got %0d want %0d", got, sent); end
   endtask

   task automatic test_reset_midstream;
      int stale;
      logic [11:0] exp_rgb;
      m_ready_i = 1'b1;
      s_valid_i = 1'b1;
      drive_rand(); s_de_i = 1'b1;
      tick;
      drive_rand(); s_de_i = 1'b1;
      tick;
      // Two pixels now in flight; reset with the sink not ready.
      s_valid_i = 1'b0; m_ready_i = 1'b0; rst_i = 1'b1;
      tick;
      n_cmp++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", m_valid_o); end
      n_cmp++; if (m_de_o !== 1'b0 || m_rgb_o !== 12'h000)
         begin n_err++; $display("FAIL rstmid_out got de=%b rgb=%h want de=0 rgb=000", m_de_o, m_rgb_o); end
      n_cmp++; if (s_ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", s_ready_o); end
      rst_i = 1'b0; m_ready_i = 1'b1;
      stale = 0;
      for (int t = 0; t < 6; t++) begin
         tick;
         if (m_valid_o) stale++;
      end
      n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL rstmid_stale got %0d emitted want 0", stale); end
      drive_rand(); s_de_i = 1'b1;
      exp_rgb = ref_px(s_bg_i, s_fg_i, s_alpha_i, s_layer_en_i, 1'b1);
      s_valid_i = 1'b1;
      tick;
      s_valid_i = 1'b0;
      n_cmp++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_early got %b want 0", m_valid_o); end
      tick;
      n_cmp++; if (m_valid_o !== 1'b1 || m_rgb_o !== exp_rgb)
         begin n_err++; $display("FAIL rstmid_first got v=%b rgb=%h want v=1 rgb=%h", m_valid_o, m_rgb_o, exp_rgb); end
      tick;
   endtask

   initial begin
      rst_i = 1'b1; s_valid_i = 1'b0; m_ready_i = 1'b0;
      drive_px(12'h000, 24'h000000, 6'h00, 2'b00, 1'b0);
      #1;
      test_reset();
      test_passthrough();
      test_opaque();
      test_rounding();
      test_blanking();
      test_backpressure();
      test_random_stream();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
